// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit-side arbitration and the
// matching receive-side demux.
package uart_pkg;

  localparam int UART_DATA_W = 9;
  localparam int RR_MAX_N    = 8;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  // Round-robin scan: returns the first set bit of req starting at ptr and
  // wrapping at n. Returns ptr when req is empty; callers qualify with |req.
  function automatic logic [2:0] rr_pick(input logic [7:0] req,
                                         input logic [2:0] ptr,
                                         input int         n);
    logic found;
    int   idx;
    rr_pick = ptr;
    found   = 1'b0;
    for (int i = 0; i < RR_MAX_N; i++) begin
      idx = int'(ptr) + i;
      if (idx >= n) idx = idx - n;
      if (i < n && !found && req[idx[2:0]]) begin
        rr_pick = idx[2:0];
        found   = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first active request at or after ptr.
module rr_arbiter
  import uart_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0] req,
  input  logic [2:0]       ptr,
  output logic [2:0]       gnt_idx,
  output logic             any_req
);

  always_comb begin
    gnt_idx = rr_pick(8'(req), ptr, N_REQ);
    any_req = |req;
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter sharing one UART transmit input among
// N_REQ requesters, with a burst limit that forces re-arbitration.
//
// state | meaning
// IDLE  | no grant; pick next requester from rr_ptr, one bubble cycle
// BUSY  | grant held; granted requester muxed straight to the UART input
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int DATA_W    = UART_DATA_W,
  parameter int MAX_BURST = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ*DATA_W-1:0] req_dat,
  input  logic [N_REQ-1:0]        req_vld,
  input  logic [N_REQ-1:0]        req_last,
  output logic [N_REQ-1:0]        req_rdy,
  output logic [DATA_W-1:0]       out_dat,
  output logic                    out_vld,
  input  logic                    out_rdy,
  output logic                    gnt_vld,
  output logic [2:0]              gnt_id,
  output logic [7:0]              burst_cnt
);

  arb_state_t  state_q, state_d;
  logic [2:0]  gnt_id_q, gnt_id_d;
  logic [2:0]  rr_ptr_q, rr_ptr_d;
  logic [7:0]  burst_cnt_q, burst_cnt_d;

  logic [2:0]        pick_idx;
  logic              any_req;
  logic [DATA_W-1:0] sel_dat;
  logic              sel_vld;
  logic              sel_last;
  logic              xfer;
  logic              burst_end;

  rr_arbiter #(.N_REQ(N_REQ)) u_rr (
    .req     (req_vld),
    .ptr     (rr_ptr_q),
    .gnt_idx (pick_idx),
    .any_req (any_req)
  );

  // The handshake towards the UART is combinational while BUSY so the word
  // accepted by the UART is exactly the one popped from the requester.
  always_comb begin
    sel_dat  = '0;
    sel_vld  = 1'b0;
    sel_last = 1'b0;
    req_rdy  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt_id_q == 3'(i)) begin
        sel_dat  = req_dat[i*DATA_W +: DATA_W];
        sel_vld  = req_vld[i];
        sel_last = req_last[i];
        if (state_q == BUSY) req_rdy[i] = out_rdy;
      end
    end
    out_dat   = (state_q == BUSY) ? sel_dat : '0;
    out_vld   = (state_q == BUSY) && sel_vld;
    xfer      = out_vld && out_rdy;
    burst_end = ({1'b0, burst_cnt_q} + 9'd1) == 9'(MAX_BURST);
  end

  always_comb begin
    state_d     = state_q;
    gnt_id_d    = gnt_id_q;
    rr_ptr_d    = rr_ptr_q;
    burst_cnt_d = burst_cnt_q;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          gnt_id_d    = pick_idx;
          burst_cnt_d = 8'd0;
          state_d     = BUSY;
        end
      end
      BUSY: begin
        if (xfer) begin
          burst_cnt_d = burst_cnt_q + 8'd1;
          if (sel_last || burst_end) begin
            state_d  = IDLE;
            rr_ptr_d = (gnt_id_q == 3'(N_REQ - 1)) ? 3'd0 : gnt_id_q + 3'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      gnt_id_q    <= 3'd0;
      rr_ptr_q    <= 3'd0;
      burst_cnt_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      gnt_id_q    <= gnt_id_d;
      rr_ptr_q    <= rr_ptr_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  assign gnt_vld   = (state_q == BUSY);
  assign gnt_id    = gnt_id_q;
  assign burst_cnt = burst_cnt_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed and randomized bench for uart_tx_arbiter against a packet-level
// reference model of the round-robin grant rules.
module tb_uart_tx_arbiter;

  localparam int N    = 4;
  localparam int DW   = 9;
  localparam int MAXB = 16;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N*DW-1:0] req_dat;
  logic [N-1:0]    req_vld;
  logic [N-1:0]    req_last;
  logic [N-1:0]    req_rdy;
  logic [DW-1:0]   out_dat;
  logic            out_vld;
  logic            out_rdy;
  logic            gnt_vld;
  logic [2:0]      gnt_id;
  logic [7:0]      burst_cnt;

  uart_tx_arbiter #(.N_REQ(N), .DATA_W(DW), .MAX_BURST(MAXB)) dut (
    .clk       (clk),
    .rst       (rst_n),
    .req_dat   (req_dat),
    .req_vld   (req_vld),
    .req_last  (req_last),
    .req_rdy   (req_rdy),
    .out_dat   (out_dat),
    .out_vld   (out_vld),
    .out_rdy   (out_rdy),
    .gnt_vld   (gnt_vld),
    .gnt_id    (gnt_id),
    .burst_cnt (burst_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Per-requester word queues: bit DW is the end-of-packet flag.
  logic [DW:0] q [N][$];
  logic [N-1:0] gap;

  // Reference model: who holds the grant, words sent in it, scan pointer.
  bit m_busy;
  int m_gnt, m_cnt, m_ptr;

  int          log_id  [$];
  logic [DW-1:0] log_dat [$];
  int          log_cyc [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      if (q[i].size() > 0) begin
        req_dat[i*DW +: DW] = q[i][0][DW-1:0];
        req_last[i]         = q[i][0][DW];
        req_vld[i]          = !gap[i];
      end else begin
        req_dat[i*DW +: DW] = '0;
        req_last[i]         = 1'b0;
        req_vld[i]          = 1'b0;
      end
    end
  endtask

  function automatic bit pending();
    pending = m_busy;
    for (int i = 0; i < N; i++) if (q[i].size() > 0) pending = 1'b1;
  endfunction

  task automatic push_word(input int id, input logic [DW-1:0] d, input bit last);
    q[id].push_back({last, d});
  endtask

  task automatic push_pkt(input int id, input int len, input int base);
    for (int j = 0; j < len; j++) q[id].push_back({(j == len - 1), DW'(base + j)});
  endtask

  // One clock: check outputs just before the edge, advance the model, then
  // retire the accepted word from its source queue after the edge.
  task automatic tick();
    bit            fire, found;
    int            fid, idx;
    logic          exp_vld;
    logic [DW-1:0] exp_dat;
    logic [N-1:0]  exp_rdy;
    @(negedge clk);
    exp_vld = m_busy && req_vld[m_gnt];
    exp_dat = m_busy ? req_dat[m_gnt*DW +: DW] : '0;
    exp_rdy = '0;
    if (m_busy) exp_rdy[m_gnt] = out_rdy;
    chk("out_vld", 32'(out_vld), 32'(exp_vld));
    chk("out_dat", 32'(out_dat), 32'(exp_dat));
    chk("req_rdy", 32'(req_rdy), 32'(exp_rdy));
    chk("gnt_vld", 32'(gnt_vld), 32'(m_busy));
    if (m_busy) begin
      chk("gnt_id", 32'(gnt_id), 32'(m_gnt));
      chk("burst_cnt", 32'(burst_cnt), 32'(m_cnt));
    end
    fire = exp_vld && out_rdy;
    fid  = m_gnt;
    if (!m_busy) begin
      found = 1'b0;
      for (int k = 0; k < N; k++) begin
        idx = (m_ptr + k) % N;
        if (!found && req_vld[idx]) begin
          found = 1'b1;
          m_gnt = idx;
          m_cnt = 0;
          m_busy = 1'b1;
        end
      end
    end else if (fire) begin
      m_cnt++;
      if (req_last[m_gnt] || m_cnt == MAXB) begin
        m_busy = 1'b0;
        m_ptr  = (m_gnt + 1) % N;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    if (fire) begin
      void'(q[fid].pop_front());
      log_id.push_back(fid);
      log_dat.push_back(exp_dat);
      log_cyc.push_back(cyc);
    end
    drive();
  endtask

  task automatic clear_all();
    for (int i = 0; i < N; i++) q[i].delete();
    gap = '0;
    m_busy = 1'b0; m_gnt = 0; m_cnt = 0; m_ptr = 0;
    log_id.delete(); log_dat.delete(); log_cyc.delete();
    drive();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_gnt_vld", 32'(gnt_vld), 32'd0);
    chk("rst_out_vld", 32'(out_vld), 32'd0);
    chk("rst_req_rdy", 32'(req_rdy), 32'd0);
    chk("rst_out_dat", 32'(out_dat), 32'd0);
    chk("rst_gnt_id", 32'(gnt_id), 32'd0);
    chk("rst_burst_cnt", 32'(burst_cnt), 32'd0);
    clear_all();
    @(negedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic run_until_empty(input int maxc, input string tag);
    int n = 0;
    while (pending() && n < maxc) begin
      tick();
      n++;
    end
    chk(tag, 32'(n < maxc), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    out_rdy = 1'b0;
    gap = '0;
    clear_all();
    @(posedge clk); #1;

    // Single requester, three-word packet.
    do_reset();
    out_rdy = 1'b1;
    c0 = cyc;
    push_word(0, 9'h041, 1'b0);
    push_word(0, 9'h042, 1'b0);
    push_word(0, 9'h143, 1'b1);
    drive();
    run_until_empty(20, "s1_timeout");
    tick();
    chk("s1_nxfer", 32'(log_dat.size()), 32'd3);
    chk("s1_w0", 32'(log_dat[0]), 32'h041);
    chk("s1_w2", 32'(log_dat[2]), 32'h143);
    chk("s1_first_lat", 32'(log_cyc[0] - c0), 32'd2);
    chk("s1_back2back", 32'(log_cyc[2] - log_cyc[0]), 32'd2);
    // Pointer now at 1: with 0 and 1 both requesting, 1 wins.
    push_word(0, 9'h0a0, 1'b1);
    push_word(1, 9'h0a1, 1'b1);
    drive();
    run_until_empty(20, "s1b_timeout");
    chk("s1_ptr_after", 32'(log_id[3]), 32'd1);

    // Round-robin over four one-word packets.
    do_reset();
    c0 = cyc;
    for (int i = 0; i < N; i++) push_word(i, DW'(9'h100 + i), 1'b1);
    drive();
    run_until_empty(30, "rr_timeout");
    for (int i = 0; i < N; i++) chk("rr_order", 32'(log_id[i]), 32'(i));
    chk("rr_total_cycles", 32'(log_cyc[N-1] - c0), 32'd8);

    // Backpressure on requester 2.
    do_reset();
    push_word(2, 9'h0c1, 1'b0);
    push_word(2, 9'h1c2, 1'b1);
    drive();
    tick();
    out_rdy = 1'b1; tick();
    out_rdy = 1'b0; tick();
    tick();
    out_rdy = 1'b1; tick();
    tick();
    chk("bp_nxfer", 32'(log_dat.size()), 32'd2);
    chk("bp_w1", 32'(log_dat[1]), 32'h1c2);
    chk("bp_released", 32'(gnt_vld), 32'd0);

    // Burst limit splits requester 1's stream; requester 3 goes in between.
    do_reset();
    push_pkt(1, 20, 9'h020);
    push_word(3, 9'h133, 1'b1);
    drive();
    run_until_empty(60, "mb_timeout");
    chk("mb_nxfer", 32'(log_id.size()), 32'd21);
    chk("mb_word16_id", 32'(log_id[15]), 32'd1);
    chk("mb_split_id", 32'(log_id[16]), 32'd3);
    chk("mb_resume_id", 32'(log_id[17]), 32'd1);
    chk("mb_resume_dat", 32'(log_dat[17]), 32'h030);

    // Reset in the middle of a packet.
    do_reset();
    push_word(1, 9'h011, 1'b1);
    drive();
    tick(); tick();
    push_pkt(2, 4, 9'h050);
    drive();
    tick(); tick();
    chk("mr_pre_vld", 32'(out_vld), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mr_gnt_vld", 32'(gnt_vld), 32'd0);
    chk("mr_out_vld", 32'(out_vld), 32'd0);
    chk("mr_req_rdy", 32'(req_rdy), 32'd0);
    chk("mr_burst_cnt", 32'(burst_cnt), 32'd0);
    clear_all();
    @(negedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    push_word(1, 9'h0e1, 1'b1);
    push_word(3, 9'h0e3, 1'b1);
    drive();
    run_until_empty(20, "mr_timeout");
    chk("mr_ptr_restart", 32'(log_id[0]), 32'd1);

    // Granted requester pauses mid-packet while another waits.
    do_reset();
    push_pkt(0, 3, 9'h070);
    drive();
    tick(); tick();
    gap[0] = 1'b1;
    push_word(1, 9'h0f1, 1'b1);
    drive();
    repeat (5) tick();
    chk("gap_held", 32'(gnt_vld), 32'd1);
    gap[0] = 1'b0;
    drive();
    run_until_empty(20, "gap_timeout");
    chk("gap_nxfer", 32'(log_id.size()), 32'd4);
    chk("gap_tail_id", 32'(log_id[2]), 32'd0);
    chk("gap_other_id", 32'(log_id[3]), 32'd1);

    // Random traffic with stalls and source gaps.
    do_reset();
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 5) == 0) begin
        int r;
        r = int'($urandom_range(0, N - 1));
        if (q[r].size() < 30) push_pkt(r, int'($urandom_range(1, 20)), int'($urandom_range(0, 511)));
      end
      for (int i = 0; i < N; i++) gap[i] = ($urandom_range(0, 5) == 0);
      out_rdy = ($urandom_range(0, 3) != 0);
      drive();
      tick();
    end
    gap = '0;
    out_rdy = 1'b1;
    drive();
    run_until_empty(3000, "rand_drain_timeout");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
